// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parameterised register file.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } regfile_state_t;

    localparam int RF_DW_DEF    = 8;
    localparam int RF_DEPTH_DEF = 4;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps one register-file entry per cycle after a clr request.
// busy, clr_we and clr_addr are decoded directly from flops.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter  int DEPTH = RF_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          clr,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    regfile_state_t state_q, state_d;
    logic [AW-1:0]  idx_q, idx_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                // clr is deliberately not looked at here: no restart, no extension.
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = idx_q;

endmodule

// File: rtl/regfile_param.sv
// Parameterised register file: two registered read ports, one write port, sequenced clear.
// Define REGFILE_BYPASS_EN to forward same-cycle accepted write data to the read registers.
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int DW       = RF_DW_DEF,
    parameter  int DEPTH    = RF_DEPTH_DEF,
    parameter  int ZERO_REG = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic [AW-1:0] RA1,
    input  logic [AW-1:0] RA2,
    input  logic [AW-1:0] RA3,
    input  logic [DW-1:0] WD3,
    input  logic          WE3,
    input  logic          clr,
    output logic [DW-1:0] RD1,
    output logic [DW-1:0] RD2,
    output logic          busy,
    output logic          wr_err
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [DW-1:0] rd1_q, rd1_d;
    logic [DW-1:0] rd2_q, rd2_d;
    logic          wr_err_q, wr_err_d;
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          wr_acc;

    // An address names real storage: inside the array and not the hard-wired zero entry.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    regfile_clear_seq #(
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .CLK      (CLK),
        .reset    (reset),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_acc   = WE3 && !busy && addr_live(RA3);
    assign wr_err_d = WE3 && !wr_acc;

    // The sweep owns the write port while busy; wr_acc is already blocked then.
    always_comb begin
        mem_d = mem_q;
        if (clr_we) begin
            mem_d[clr_addr] = '0;
        end else if (wr_acc) begin
            mem_d[RA3] = WD3;
        end
    end

    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (addr_live(RA1)) rd1_d = mem_q[RA1];
        if (addr_live(RA2)) rd2_d = mem_q[RA2];
`ifdef REGFILE_BYPASS_EN
        if (wr_acc && (RA3 == RA1)) rd1_d = WD3;
        if (wr_acc && (RA3 == RA2)) rd2_d = WD3;
`endif
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            // NOTE: the array is reset here because the block must come out of reset reading all zeros.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign RD1    = rd1_q;
    assign RD2    = rd2_q;
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: DUT A (DEPTH=4) and DUT B (DEPTH=5, ZERO_REG=1).
`timescale 1ns/1ps
module tb_regfile_param;

    localparam int DA = 0, DB = 1;
    localparam int S_RD1 = 0, S_RD2 = 1, S_BUSY = 2, S_WERR = 3;

    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    logic [1:0] a_ra1, a_ra2, a_ra3;
    logic [7:0] a_wd3, a_rd1, a_rd2;
    logic       a_we3, a_clr, a_busy, a_werr;

    logic [2:0] b_ra1, b_ra2, b_ra3;
    logic [7:0] b_wd3, b_rd1, b_rd2;
    logic       b_we3, b_clr, b_busy, b_werr;

    regfile_param #(.DW(8), .DEPTH(4), .ZERO_REG(0)) u_a (
        .CLK(CLK), .reset(reset), .RA1(a_ra1), .RA2(a_ra2), .RA3(a_ra3),
        .WD3(a_wd3), .WE3(a_we3), .clr(a_clr), .RD1(a_rd1), .RD2(a_rd2),
        .busy(a_busy), .wr_err(a_werr)
    );

    regfile_param #(.DW(8), .DEPTH(5), .ZERO_REG(1)) u_b (
        .CLK(CLK), .reset(reset), .RA1(b_ra1), .RA2(b_ra2), .RA3(b_ra3),
        .WD3(b_wd3), .WE3(b_we3), .clr(b_clr), .RD1(b_rd1), .RD2(b_rd2),
        .busy(b_busy), .wr_err(b_werr)
    );

    typedef struct {
        int         due;
        int         dut;
        int         sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queue an expectation for the negedge of cycle cyc+dly.
    task automatic push_exp(input int dut, input int sig, input logic [7:0] val,
                            input string name, input int dly);
        exp_t e;
        e.due  = cyc + dly;
        e.dut  = dut;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    function automatic logic [7:0] actual(input int dut, input int sig);
        if (dut == DA) begin
            case (sig)
                S_RD1:   return a_rd1;
                S_RD2:   return a_rd2;
                S_BUSY:  return {7'b0, a_busy};
                default: return {7'b0, a_werr};
            endcase
        end
        case (sig)
            S_RD1:   return b_rd1;
            S_RD2:   return b_rd2;
            S_BUSY:  return {7'b0, b_busy};
            default: return {7'b0, b_werr};
        endcase
    endfunction

    // Monitor: outputs are presented every cycle; compare whatever is due now.
    always @(negedge CLK) begin : monitor
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                check(sb[i].name, 32'(actual(sb[i].dut, sb[i].sig)), 32'(sb[i].val));
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        a_ra1 = '0; a_ra2 = '0; a_ra3 = '0; a_wd3 = '0; a_we3 = 1'b0; a_clr = 1'b0;
        b_ra1 = '0; b_ra2 = '0; b_ra3 = '0; b_wd3 = '0; b_we3 = 1'b0; b_clr = 1'b0;

        // Reset state
        step(); step();
        for (int s = 0; s < 4; s++) begin
            push_exp(DA, s, 8'h00, "a_reset_state", 0);
            push_exp(DB, s, 8'h00, "b_reset_state", 0);
        end
        step();
        reset = 1'b1;

        // Read every address on both DUTs after reset
        for (int a = 0; a < 8; a++) begin
            a_ra1 = 2'(a); a_ra2 = ~2'(a);
            b_ra1 = 3'(a); b_ra2 = ~3'(a);
            push_exp(DA, S_RD1, 8'h00, "a_rd1_after_reset", 1);
            push_exp(DA, S_RD2, 8'h00, "a_rd2_after_reset", 1);
            push_exp(DB, S_RD1, 8'h00, "b_rd1_after_reset", 1);
            push_exp(DB, S_RD2, 8'h00, "b_rd2_after_reset", 1);
            push_exp(DA, S_BUSY, 8'h00, "a_busy_idle", 1);
            step();
        end

        // Write 03 to entry 3, then read 3 and 1
        a_we3 = 1'b1; a_ra3 = 2'd3; a_wd3 = 8'h03;
        push_exp(DA, S_WERR, 8'h00, "a_wr_ok_no_err", 1);
        step();
        a_we3 = 1'b0; a_ra1 = 2'd3; a_ra2 = 2'd1;
        push_exp(DA, S_RD1, 8'h03, "a_rd1_entry3", 1);
        push_exp(DA, S_RD2, 8'h00, "a_rd2_entry1", 1);
        step();

        // Same-cycle write/read collision on entry 2 (held 11)
        a_we3 = 1'b1; a_ra3 = 2'd2; a_wd3 = 8'h11;
        step();
        a_ra3 = 2'd2; a_wd3 = 8'hA5; a_ra1 = 2'd2; a_ra2 = 2'd3;
`ifdef REGFILE_BYPASS_EN
        push_exp(DA, S_RD1, 8'hA5, "a_collision_bypass", 1);
`else
        push_exp(DA, S_RD1, 8'h11, "a_collision_old", 1);
`endif
        push_exp(DA, S_RD2, 8'h03, "a_rd2_no_collision", 1);
        step();
        a_we3 = 1'b0;
        push_exp(DA, S_RD1, 8'hA5, "a_collision_next", 1);
        step();

        // Fill with FF, then a sweep with clr held as a level and a write during it
        for (int e = 0; e < 4; e++) begin
            a_we3 = 1'b1; a_ra3 = 2'(e); a_wd3 = 8'hFF;
            step();
        end
        a_we3 = 1'b0; a_clr = 1'b1;
        for (int d = 1; d <= 4; d++) push_exp(DA, S_BUSY, 8'h01, "a_busy_sweep", d);
        push_exp(DA, S_BUSY, 8'h00, "a_busy_fall", 5);
        push_exp(DA, S_WERR, 8'h00, "a_clr_no_err", 1);
        step();
        a_we3 = 1'b1; a_ra3 = 2'd1; a_wd3 = 8'h55;
        push_exp(DA, S_WERR, 8'h01, "a_wr_err_in_clear", 1);
        step();
        a_we3 = 1'b0; a_ra1 = 2'd0; a_ra2 = 2'd3;
        push_exp(DA, S_RD1, 8'h00, "a_partial_cleared", 1);
        push_exp(DA, S_RD2, 8'hFF, "a_partial_pending", 1);
        push_exp(DA, S_WERR, 8'h00, "a_wr_err_one_cycle", 1);
        step();
        step();
        a_clr = 1'b0;
        step();
        push_exp(DA, S_BUSY, 8'h00, "a_no_restart", 1);
        for (int e = 0; e < 4; e++) begin
            a_ra1 = 2'(e); a_ra2 = 2'(e);
            push_exp(DA, S_RD1, 8'h00, "a_rd1_after_clear", 1);
            push_exp(DA, S_RD2, 8'h00, "a_rd2_after_clear", 1);
            step();
        end

        // clr and write together in IDLE: write lands, sweep erases it
        a_clr = 1'b1; a_we3 = 1'b1; a_ra3 = 2'd2; a_wd3 = 8'h77;
        push_exp(DA, S_WERR, 8'h00, "a_clr_wr_no_err", 1);
        push_exp(DA, S_BUSY, 8'h01, "a_clr_wr_busy", 1);
        step();
        a_clr = 1'b0; a_we3 = 1'b0; a_ra1 = 2'd2;
        push_exp(DA, S_RD1, 8'h77, "a_clr_wr_written", 1);
        step(); step(); step();
        push_exp(DA, S_RD1, 8'h00, "a_clr_wr_erased", 1);
        step();

        // DUT B: zero register and out-of-range handling
        b_we3 = 1'b1; b_ra3 = 3'd0; b_wd3 = 8'h7E; b_ra1 = 3'd0;
        push_exp(DB, S_WERR, 8'h01, "b_zero_reg_wr_err", 1);
        push_exp(DB, S_RD1, 8'h00, "b_zero_reg_no_fwd", 1);
        step();
        b_ra3 = 3'd4; b_wd3 = 8'h42; b_ra1 = 3'd7; b_ra2 = 3'd0;
        push_exp(DB, S_WERR, 8'h00, "b_wr_entry4_ok", 1);
        push_exp(DB, S_RD1, 8'h00, "b_rd_addr7", 1);
        push_exp(DB, S_RD2, 8'h00, "b_rd_zero_reg", 1);
        step();
        b_ra3 = 3'd6; b_wd3 = 8'h33; b_ra1 = 3'd4; b_ra2 = 3'd6;
        push_exp(DB, S_WERR, 8'h01, "b_wr_oob_err", 1);
        push_exp(DB, S_RD1, 8'h42, "b_rd_entry4", 1);
        push_exp(DB, S_RD2, 8'h00, "b_rd_oob_no_fwd", 1);
        step();
        b_we3 = 1'b0; b_ra1 = 3'd0; b_ra2 = 3'd4;
        push_exp(DB, S_RD1, 8'h00, "b_zero_reg_after", 1);
        push_exp(DB, S_RD2, 8'h42, "b_entry4_kept", 1);
        push_exp(DB, S_WERR, 8'h00, "b_wr_err_cleared", 1);
        step();

        // Reset in the middle of a sweep
        a_we3 = 1'b1; a_ra3 = 2'd1; a_wd3 = 8'h99;
        step();
        a_we3 = 1'b0; a_clr = 1'b1; a_ra1 = 2'd1; a_ra2 = 2'd1;
        step();
        a_clr = 1'b0;
        push_exp(DA, S_RD1, 8'h99, "a_pre_reset_rd1", 0);
        push_exp(DA, S_RD2, 8'h99, "a_pre_reset_rd2", 0);
        push_exp(DA, S_BUSY, 8'h01, "a_pre_reset_busy", 0);
        step();
        reset = 1'b0;
        push_exp(DA, S_RD1, 8'h00, "a_reset_mid_rd1", 0);
        push_exp(DA, S_RD2, 8'h00, "a_reset_mid_rd2", 0);
        push_exp(DA, S_BUSY, 8'h00, "a_reset_mid_busy", 0);
        step();
        reset = 1'b1; a_ra2 = 2'd3;
        for (int d = 1; d <= 3; d++) push_exp(DA, S_BUSY, 8'h00, "a_busy_after_reset", d);
        push_exp(DA, S_RD1, 8'h00, "a_entry1_reset", 1);
        push_exp(DA, S_RD2, 8'h00, "a_entry3_reset", 1);
        step(); step(); step();

        // Every queued expectation must have been consumed
        step(); step();
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file, the successor to the fixed 4×8 register file in the Lab2 datapath.
- Width, depth and an optional hard-wired zero register are configurable.
- The two read ports are registered.
- A `clr` command starts a sequenced clear that sweeps one entry per cycle and reports `busy`.
- Dropped writes are flagged.

The block sits between the ALU result bus (write port) and the operand-select muxes (read ports).

## Interface
Parameters:
- `DW`, 8, data width in bits (≥1)
- `DEPTH`, 4, number of entries (≥2, need not be a power of two)
- `ZERO_REG`, 0, when 1 entry 0 always reads 0 and writes to it are dropped
- `AW`, `$clog2(DEPTH)`, address width (localparam, derived)

Ports:
- `CLK`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `RA1`  in  AW  read address, port 1
- `RA2`  in  AW  read address, port 2
- `RA3`  in  AW  write address
- `WD3`  in  DW  write data
- `WE3`  in  1  write enable, active-high
- `clr`  in  1  start sequenced clear (single-cycle pulse or level)
- `RD1`  out  DW  registered read data, port 1
- `RD2`  out  DW  registered read data, port 2
- `busy`  out  1  high while clear sweep in progress
- `wr_err`  out  1  one-cycle pulse: a requested write was dropped

## Operation
- Reset (`reset`=0), asynchronous:
  - all entries 0, `RD1`/`RD2`=0, `busy`=0, `wr_err`=0
  - state IDLE, sweep index 0
- FSM states: IDLE, CLEAR.
  - IDLE→CLEAR on `clr`=1 at an edge; index←0.
  - CLEAR: at each edge, write 0 to entry[index] and increment index. After entry DEPTH-1 is written, return to IDLE.
  - A clear takes exactly DEPTH cycles.
  - `clr` is ignored while in CLEAR (no restart, no extension).
- Write:
  - Accepted when `WE3`=1 and all of: state IDLE, `RA3`<DEPTH, and not (ZERO_REG && `RA3`=0).
  - Any other `WE3`=1 cycle is dropped, and `wr_err`=1 on the following cycle.
- `clr` and `WE3` together in IDLE: the write is performed at that edge, then the sweep starts next cycle and erases it.
- Read:
  - `RDn` ← entry[`RAn`] at each edge.
  - `RAn`≥DEPTH reads 0.
  - ZERO_REG && `RAn`=0 reads 0.
- Reads are allowed during CLEAR and return the partially cleared contents as of that edge.
- `RA1`=`RA2` is legal; both ports return the same value.

## Timing
- Read latency 1 cycle: address presented before edge N, data valid after edge N.
- Write takes effect at edge N; a read of the same address in cycle N+1 returns the new data.
- Same-cycle write/read collision: behaviour set by the bypass macro (see Configuration).
- `busy`:
  - rises after the edge that samples `clr`
  - high for exactly DEPTH cycles
  - falls after the edge that clears entry DEPTH-1
- `wr_err` is registered: it pulses for 1 cycle, the cycle after the dropped request.
- Reset asserted mid-sweep: immediate IDLE, all outputs 0, sweep abandoned; contents are all 0 in any case.

## Configuration
- `REGFILE_BYPASS_EN` defined: on a same-cycle collision (accepted write with `RA3`=`RAn`), `RDn` registers `WD3` (new data).
- `REGFILE_BYPASS_EN` undefined: `RDn` registers the pre-write entry (old data).
- Dropped writes are never forwarded, with or without the macro.

## Structure
- Package `regfile_pkg` holds:
  - `regfile_state_t` enum {IDLE, CLEAR}
  - default constants `RF_DW_DEF`=8, `RF_DEPTH_DEF`=4
- Sub-module `regfile_clear_seq`:
  - contains the FSM and the sweep counter
  - outputs `busy`, `clr_we` and `clr_addr`
- Top module holds the storage array, the write arbitration (sweep has priority; user writes are blocked in CLEAR), the read registers and the bypass logic.

## Test plan
- Reset then read all addresses → `RD1`=`RD2`=0, `busy`=0.
- DW=8, DEPTH=4: write 8'h03→entry 3, then `RA1`=3, `RA2`=1 → next cycle `RD1`=8'h03, `RD2`=8'h00.
- Same-cycle write 8'hA5→entry 2 with `RA1`=2 (entry held 8'h11):
  - with macro → `RD1`=8'hA5
  - without macro → `RD1`=8'h11; next cycle 8'hA5
- Fill entries with 8'hFF, pulse `clr`, attempt a write at sweep cycle 1 → `busy` high exactly 4 cycles, `wr_err` pulse, all entries 0 afterward.
- ZERO_REG=1, DEPTH=5:
  - write 8'h7E to entry 0 → `wr_err`=1, read entry 0 = 0
  - `RA1`=7 reads 0
- Assert `reset` at sweep cycle 2 → `busy`, `RD1` and `RD2` go 0 immediately. After release, `clr`=0 and `busy` stays 0.
